// File: rtl/mul_div_if.sv
// Start/busy/done handshake and result bus between the execute stage and mul_div_unit.
interface mul_div_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             busy;
   logic             done;
   logic             dbz;
   logic [WIDTH-1:0] result_hi;
   logic [WIDTH-1:0] result_lo;

   modport master (
      output start, op, src_a, src_b,
      input  busy, done, dbz, result_hi, result_lo
   );

   modport slave (
      input  start, op, src_a, src_b,
      output busy, done, dbz, result_hi, result_lo
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply (shift-add) / divide (restoring) unit, WIDTH steps per operation.
// Signed operands are reduced to magnitudes at accept; signs are reapplied in FIX.
module mul_div_unit #(
   parameter int WIDTH = 16
) (
   input logic      clk,
   input logic      rst_n,
   mul_div_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam int ACC_W = 2 * WIDTH + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [ACC_W-1:0]   acc;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   raw_a;
   logic               is_div;
   logic               neg_lo;
   logic               neg_hi;
   logic               b_zero;

   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   in_mag_a;
   logic [WIDTH-1:0]   in_mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_s;
   logic [WIDTH:0]     rem_diff;
   logic [ACC_W-1:0]   mul_step;
   logic [ACC_W-1:0]   div_step;
   logic [2*WIDTH-1:0] product;

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (WIDTH'(0) - v) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v,
                                                        input logic neg);
      return neg ? ((2*WIDTH)'(0) - v) : v;
   endfunction

   always_comb begin
      sign_a   = bus.op[0] & bus.src_a[WIDTH-1];
      sign_b   = bus.op[0] & bus.src_b[WIDTH-1];
      in_mag_a = cond_neg(bus.src_a, sign_a);
      in_mag_b = cond_neg(bus.src_b, sign_b);
      // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
      mul_sum  = acc[2*WIDTH:WIDTH] + {1'b0, mag_a};
      mul_step = acc[0] ? {1'b0, mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH:1]};
      // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step
      rem_s    = acc[2*WIDTH-1:WIDTH-1];
      rem_diff = rem_s - {1'b0, mag_b};
      div_step = (rem_s >= {1'b0, mag_b}) ? {rem_diff, acc[WIDTH-2:0], 1'b1}
                                          : {rem_s, acc[WIDTH-2:0], 1'b0};
      product  = cond_neg_wide(acc[2*WIDTH-1:0], neg_lo);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         acc           <= '0;
         mag_a         <= '0;
         mag_b         <= '0;
         raw_a         <= '0;
         is_div        <= 1'b0;
         neg_lo        <= 1'b0;
         neg_hi        <= 1'b0;
         b_zero        <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.dbz       <= 1'b0;
         bus.result_hi <= '0;
         bus.result_lo <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  state    <= CALC;
                  bus.busy <= 1'b1;
                  cnt      <= '0;
                  is_div   <= bus.op[1];
                  neg_lo   <= sign_a ^ sign_b;
                  neg_hi   <= bus.op[1] ? sign_a : (sign_a ^ sign_b);
                  mag_a    <= in_mag_a;
                  mag_b    <= in_mag_b;
                  raw_a    <= bus.src_a;
                  b_zero   <= (bus.src_b == '0);
                  acc      <= bus.op[1] ? {{(WIDTH+1){1'b0}}, in_mag_a}
                                        : {{(WIDTH+1){1'b0}}, in_mag_b};
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               acc <= is_div ? div_step : mul_step;
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST) state <= FIX;
            end
            FIX: begin
               state    <= DONE;
               bus.busy <= 1'b0;
               bus.done <= 1'b1;
               if (!is_div) begin
                  bus.result_hi <= product[2*WIDTH-1:WIDTH];
                  bus.result_lo <= product[WIDTH-1:0];
                  bus.dbz       <= 1'b0;
               end else if (b_zero) begin
                  bus.result_hi <= raw_a;
                  bus.result_lo <= '1;
                  bus.dbz       <= 1'b1;
               end else begin
                  bus.result_hi <= cond_neg(acc[2*WIDTH-1:WIDTH], neg_hi);
                  bus.result_lo <= cond_neg(acc[WIDTH-1:0], neg_lo);
                  bus.dbz       <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed cases plus random ops against an arithmetic model.
module tb_mul_div_unit;
   localparam int W   = 16;
   localparam int LAT = W + 1;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;
   exp_t sb[$];
   exp_t last_exp;

   mul_div_if #(.WIDTH(W)) bus ();

   mul_div_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on sign-extended or zero-extended operands.
   function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      exp_t   e;
      longint ua, ub, sa, sb_v, p, q, r;
      ua   = longint'(a);
      ub   = longint'(b);
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      e.dbz = 1'b0;
      e.cyc = 0;
      p = 0; q = 0; r = 0;
      case (op)
         2'b00: p = ua * ub;
         2'b01: p = sa * sb_v;
         2'b10: begin
            if (ub == 0) begin q = -1; r = ua; e.dbz = 1'b1; end
            else begin q = ua / ub; r = ua % ub; end
         end
         default: begin
            if (ub == 0) begin q = -1; r = ua; e.dbz = 1'b1; end
            else if (sa == -(longint'(1) << (W - 1)) && sb_v == -1) begin q = sa; r = 0; end
            else begin q = sa / sb_v; r = sa % sb_v; end
         end
      endcase
      if (op[1]) begin
         e.hi = r[W-1:0];
         e.lo = q[W-1:0];
      end else begin
         e.hi = p[2*W-1:W];
         e.lo = p[W-1:0];
      end
      return e;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return W'(1) << (W - 1);
         3:       return W'(1);
         default: return W'($urandom);
      endcase
   endfunction

   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold);
      exp_t e;
      int   n;
      n = 0;
      @(negedge clk);
      while (bus.busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("issue_wait_cycles", 64'(n), 64'd0);
      bus.start = 1'b1;
      bus.op    = op;
      bus.src_a = a;
      bus.src_b = b;
      e     = model(op, a, b);
      e.cyc = cyc + 1 + LAT;
      sb.push_back(e);
      last_exp = e;
      @(negedge clk);
      bus.start = hold;
      bus.op    = 2'($urandom);
      bus.src_a = W'($urandom);
      bus.src_b = W'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            check("done_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("result_hi", 64'(bus.result_hi), 64'(e.hi));
               check("result_lo", 64'(bus.result_lo), 64'(e.lo));
               check("dbz", 64'(bus.dbz), 64'(e.dbz));
               check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.src_a = '0;
      bus.src_b = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      check("reset_dbz", 64'(bus.dbz), 64'd0);
      check("reset_hi", 64'(bus.result_hi), 64'd0);
      check("reset_lo", 64'(bus.result_lo), 64'd0);
      rst_n = 1'b1;

      issue(2'b00, 16'hFFFF, 16'hFFFF, 1'b0);
      issue(2'b01, 16'hFFFD, 16'h0005, 1'b0);
      issue(2'b01, 16'h8000, 16'h8000, 1'b0);
      issue(2'b10, 16'd100, 16'd7, 1'b0);
      issue(2'b11, 16'hFFF9, 16'h0002, 1'b0);
      issue(2'b11, 16'h0007, 16'hFFFE, 1'b0);
      issue(2'b11, 16'h8000, 16'hFFFF, 1'b0);
      issue(2'b10, 16'h1234, 16'h0000, 1'b0);
      issue(2'b00, 16'h0002, 16'h0003, 1'b0);

      // Start pulses while busy must be ignored
      issue(2'b01, 16'hF00D, 16'h0123, 1'b0);
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 2'b10;
      bus.src_a = 16'h7777;
      bus.src_b = 16'h0000;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (6) @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 2'b11;
      bus.src_a = 16'h5555;
      @(negedge clk);
      bus.start = 1'b0;

      // Back-to-back: start held through the done cycle
      issue(2'b00, 16'd3, 16'd4, 1'b1);
      issue(2'b10, 16'd9, 16'd3, 1'b0);
      drain();

      // Reset in the middle of CALC aborts without a done pulse
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 2'b00;
      bus.src_a = 16'd7;
      bus.src_b = 16'd9;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      check("abort_hi", 64'(bus.result_hi), 64'd0);
      check("abort_lo", 64'(bus.result_lo), 64'd0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      issue(2'b00, 16'd5, 16'd5, 1'b0);

      for (int i = 0; i < 40; i++) begin
         issue(2'($urandom), pick(), pick(), 1'($urandom_range(0, 1)));
      end
      @(negedge clk);
      bus.start = 1'b0;
      drain();

      repeat (3) @(negedge clk);
      check("hold_hi", 64'(bus.result_hi), 64'(last_exp.hi));
      check("hold_lo", 64'(bus.result_lo), 64'(last_exp.lo));
      check("hold_dbz", 64'(bus.dbz), 64'(last_exp.dbz));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
